// File: rtl/fdiv_seq.sv
// Single-precision divide wrapper around an external mantissa divider (mdiv):
// unpacks operands, short-circuits special values, sequences mdiv and packs the result.
`timescale 1ns/1ps

module fdiv_seq #(
    parameter int WIDTH = 23,
    parameter int EXP   = 8,
    parameter int LAT   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP+WIDTH:0] a,
    input  logic [EXP+WIDTH:0] b,
    input  logic               round_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP+WIDTH:0] y,
    output logic [3:0]         flags,
    output logic               md_reset,
    output logic               md_round,
    output logic [WIDTH-1:0]   md_m1,
    output logic [WIDTH-1:0]   md_m2,
    input  logic [WIDTH-1:0]   md_m3,
    input  logic               md_dec
);

    localparam int FW = 1 + EXP + WIDTH;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0]         CNT_LOAD = CW'(LAT - 1);
    localparam logic signed [EXP+1:0] BIAS     = (EXP+2)'((1 << (EXP - 1)) - 1);
    localparam logic signed [EXP+1:0] EMAX     = (EXP+2)'((1 << EXP) - 1);
    localparam logic [EXP-1:0]        EXP_ONES = '1;
    localparam logic [FW-1:0]         QNAN     = {1'b0, {EXP{1'b1}}, 1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] FLAG_INVALID   = 4'b1000;
    localparam logic [3:0] FLAG_DIVZERO   = 4'b0100;
    localparam logic [3:0] FLAG_OVERFLOW  = 4'b0010;
    localparam logic [3:0] FLAG_UNDERFLOW = 4'b0001;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    state_t state, state_next;

    logic [EXP-1:0]   a_exp, b_exp, ea_r, eb_r;
    logic [WIDTH-1:0] a_man, b_man;
    logic             q_sign, sign_r;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic             is_special;
    logic [FW-1:0]    special_y;
    logic [3:0]       special_flags;
    logic [CW-1:0]    cnt;
    logic signed [EXP+1:0] e_calc;
    logic             e_ovf, e_unf;

    assign a_exp  = a[FW-2 -: EXP];
    assign b_exp  = b[FW-2 -: EXP];
    assign a_man  = a[WIDTH-1:0];
    assign b_man  = b[WIDTH-1:0];
    assign q_sign = a[FW-1] ^ b[FW-1];

    // Subnormal inputs classify as zero, so an all-zero exponent is enough.
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_man != '0);

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        is_special    = 1'b1;
        special_y     = '0;
        special_flags = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_y     = QNAN;
            special_flags = FLAG_INVALID;
        end else if (b_zero && !a_inf) begin
            special_y     = {q_sign, {EXP{1'b1}}, {WIDTH{1'b0}}};
            special_flags = FLAG_DIVZERO;
        end else if (a_inf) begin
            special_y     = {q_sign, {EXP{1'b1}}, {WIDTH{1'b0}}};
        end else if (a_zero || b_inf) begin
            special_y     = {q_sign, {(FW-1){1'b0}}};
        end else begin
            is_special    = 1'b0;
        end
    end

    // Biased result exponent; the extra two bits hold both overflow and negative results.
    assign e_calc = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + BIAS
                  - $signed({{(EXP+1){1'b0}}, md_dec});
    assign e_ovf  = (e_calc >= EMAX);
    assign e_unf  = e_calc[EXP+1] || (e_calc == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = is_special ? DONE : LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (cnt == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign md_reset  = reset || (state == LAUNCH);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y        <= '0;
            flags    <= '0;
            sign_r   <= 1'b0;
            ea_r     <= '0;
            eb_r     <= '0;
            md_m1    <= '0;
            md_m2    <= '0;
            md_round <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r   <= q_sign;
                        ea_r     <= a_exp;
                        eb_r     <= b_exp;
                        md_m1    <= a_man;
                        md_m2    <= b_man;
                        md_round <= round_mode;
                        flags    <= is_special ? special_flags : 4'b0000;
                        if (is_special) y <= special_y;
                    end
                end
                LAUNCH: cnt <= CNT_LOAD;
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (e_ovf) begin
                        // RZ never rounds up to infinity, so it saturates to max finite.
                        y     <= md_round ? {sign_r, {(EXP-1){1'b1}}, 1'b0, {WIDTH{1'b1}}}
                                          : {sign_r, {EXP{1'b1}}, {WIDTH{1'b0}}};
                        flags <= FLAG_OVERFLOW;
                    end else if (e_unf) begin
                        y     <= {sign_r, {(FW-1){1'b0}}};
                        flags <= FLAG_UNDERFLOW;
                    end else begin
                        y     <= {sign_r, e_calc[EXP-1:0], md_m3};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: a behavioural mdiv stand-in plus an arithmetic
// reference model of the divide, exercised with directed and random operands.
`timescale 1ns/1ps

module tb_fdiv_seq;

    localparam int WIDTH = 23;
    localparam int EXP   = 8;
    localparam int LAT   = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        round_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;
    logic [3:0]  flags;
    logic        md_reset, md_round, md_dec;
    logic [22:0] md_m1, md_m2, md_m3;
    logic [23:0] mdiv_ok;

    int pass_cnt = 0;
    int total_cnt = 0;
    int md_cnt = LAT;
    int md_pulses = 0;

    fdiv_seq #(.WIDTH(WIDTH), .EXP(EXP), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .round_mode(round_mode), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flags(flags), .md_reset(md_reset), .md_round(md_round),
        .md_m1(md_m1), .md_m2(md_m2), .md_m3(md_m3), .md_dec(md_dec)
    );

    always #5 clk = ~clk;

    // Correctly rounded quotient of the two significands: {quotient < 1, 23-bit fraction}.
    function automatic logic [23:0] mant_div(input logic [22:0] m1, input logic [22:0] m2, input logic rm);
        longint unsigned na, nb, num, q, r;
        logic dec;
        na  = 64'({1'b1, m1});
        nb  = 64'({1'b1, m2});
        dec = (na < nb);
        num = dec ? (na << 24) : (na << 23);
        q   = num / nb;
        r   = num % nb;
        if (!rm && ((2 * r > nb) || (2 * r == nb && q[0]))) q = q + 1;
        return {dec, q[22:0]};
    endfunction

    // mdiv stand-in: output is wrong until LAT-1 cycles after md_reset drops.
    always @(posedge clk) begin
        if (md_reset) md_cnt <= 0;
        else if (md_cnt < LAT) md_cnt <= md_cnt + 1;
        if (md_reset && !reset) md_pulses <= md_pulses + 1;
    end

    always_comb begin
        mdiv_ok = mant_div(md_m1, md_m2, md_round);
        if (md_cnt >= LAT - 1) {md_dec, md_m3} = mdiv_ok;
        else                   {md_dec, md_m3} = mdiv_ok ^ 24'hA5A5A5;
    end

    // Reference divide: returns {flags, y}.
    function automatic logic [35:0] ref_div(input logic [31:0] x, input logic [31:0] d, input logic rm);
        int ex, ed, e;
        logic s, xz, dz, xi, di, xn, dn;
        logic [23:0] md;
        s  = x[31] ^ d[31];
        ex = int'(x[30:23]);
        ed = int'(d[30:23]);
        xz = (ex == 0);  dz = (ed == 0);
        xi = (ex == 255) && (x[22:0] == 0);  di = (ed == 255) && (d[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);  dn = (ed == 255) && (d[22:0] != 0);
        if (xn || dn || (xz && dz) || (xi && di)) return {4'b1000, 32'h7FC00000};
        if (dz && !xi) return {4'b0100, s, 31'h7F800000};
        if (xi)        return {4'b0000, s, 31'h7F800000};
        if (xz || di)  return {4'b0000, s, 31'h0};
        md = mant_div(x[22:0], d[22:0], rm);
        e  = ex - ed + 127 - int'(md[23]);
        if (e >= 255) return {4'b0010, s, rm ? 31'h7F7FFFFF : 31'h7F800000};
        if (e <= 0)   return {4'b0001, s, 31'h0};
        return {4'b0000, s, 8'(e), md[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        int sel;
        sel = $urandom_range(0, 19);
        m   = 23'($urandom);
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 1) m = '0; end
        else if (sel < 8)  e = 8'($urandom_range(1, 254));
        else               e = 8'($urandom_range(110, 144));
        if (sel == 2) m = '0;
        return {1'($urandom), e, m};
    endfunction

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Presents one operand pair and waits (bounded) for the result; lat counts edges from accept.
    task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic rm,
                         input bit do_drain, output logic [31:0] y_o, output logic [3:0] f_o,
                         output int lat);
        int guard;
        @(negedge clk);
        a = op_a; b = op_b; round_mode = rm; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; round_mode = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 4 * LAT + 10) begin @(posedge clk); #1; lat++; end
        y_o = y; f_o = flags;
        if (do_drain) drain();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        total_cnt++; if (md_reset !== 1'b1) $display("FAIL reset_md_reset: got %b expected 1", md_reset); else pass_cnt++;
        total_cnt++; if ({out_valid, y, flags} !== 37'd0)
            $display("FAIL reset_outputs: got out_valid=%b y=%h flags=%b expected all zero", out_valid, y, flags); else pass_cnt++;
        total_cnt++; if ({md_m1, md_m2, md_round} !== 47'd0)
            $display("FAIL reset_md_regs: got m1=%h m2=%h round=%b expected zero", md_m1, md_m2, md_round); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if ({in_ready, md_reset} !== 2'b10)
            $display("FAIL reset_release: got in_ready=%b md_reset=%b expected 1/0", in_ready, md_reset); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [31:0] yo; logic [3:0] fo; int lat, p0;
        p0 = md_pulses;
        do_op(32'h40C00000, 32'h40000000, 1'b0, 1'b1, yo, fo, lat);
        total_cnt++; if ({fo, yo} !== {4'b0000, 32'h40400000})
            $display("FAIL basic_6div2: got y=%h flags=%b expected y=40400000 flags=0000", yo, fo); else pass_cnt++;
        total_cnt++; if (lat !== LAT + 2) $display("FAIL basic_latency: got %0d expected %0d", lat, LAT + 2); else pass_cnt++;
        total_cnt++; if (md_pulses - p0 !== 1) $display("FAIL basic_md_reset_pulse: got %0d cycles expected 1", md_pulses - p0); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_back_to_idle: got in_ready=%b expected 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_rounding();
        logic [31:0] yo; logic [3:0] fo; int lat;
        do_op(32'h3F800000, 32'h40400000, 1'b0, 1'b1, yo, fo, lat);
        total_cnt++; if ({fo, yo} !== {4'b0000, 32'h3EAAAAAB})
            $display("FAIL third_rne: got y=%h flags=%b expected y=3EAAAAAB flags=0000", yo, fo); else pass_cnt++;
        do_op(32'h3F800000, 32'h40400000, 1'b1, 1'b1, yo, fo, lat);
        total_cnt++; if ({fo, yo} !== {4'b0000, 32'h3EAAAAAA})
            $display("FAIL third_rz: got y=%h flags=%b expected y=3EAAAAAA flags=0000", yo, fo); else pass_cnt++;
        do_op(32'hC1200000, 32'h40800000, 1'b0, 1'b1, yo, fo, lat);
        total_cnt++; if ({fo, yo} !== {4'b0000, 32'hC0200000})
            $display("FAIL neg_10div4: got y=%h flags=%b expected y=C0200000 flags=0000", yo, fo); else pass_cnt++;
    endtask

    task automatic test_specials();
        logic [31:0] sa [11] = '{32'h3F800000, 32'h00000000, 32'h7F800001, 32'h3F800000, 32'h7F800000, 32'hFF800000,
                                 32'h00000000, 32'h40400000, 32'h00400000, 32'hBF800000, 32'h7F800000};
        logic [31:0] sb [11] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'hFFC00000, 32'hFF800000, 32'h40000000,
                                 32'hC0A00000, 32'h7F800000, 32'h40000000, 32'h00000001, 32'h00000000};
        logic [31:0] sy [11] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                                 32'h80000000, 32'h00000000, 32'h00000000, 32'hFF800000, 32'h7F800000};
        logic [3:0]  sf [11] = '{4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        logic [31:0] yo; logic [3:0] fo; int lat, p0;
        p0 = md_pulses;
        for (int i = 0; i < 11; i++) begin
            do_op(sa[i], sb[i], 1'($urandom), 1'b1, yo, fo, lat);
            total_cnt++; if ({fo, yo} !== {sf[i], sy[i]})
                $display("FAIL special_%0d: %h/%h got y=%h flags=%b expected y=%h flags=%b", i, sa[i], sb[i], yo, fo, sy[i], sf[i]);
            else pass_cnt++;
            total_cnt++; if (lat !== 1) $display("FAIL special_latency_%0d: got %0d expected 1", i, lat); else pass_cnt++;
        end
        total_cnt++; if (md_pulses !== p0) $display("FAIL special_no_md_reset: got %0d pulses expected 0", md_pulses - p0); else pass_cnt++;
    endtask

    task automatic test_range();
        logic [31:0] ra [6] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00800000, 32'h7F7FFFFF, 32'h00800000};
        logic [31:0] rb [6] = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40000000, 32'h3F800000, 32'h3F800000};
        logic        rr [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ry [6] = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00000000, 32'h7F7FFFFF, 32'h00800000};
        logic [3:0]  rf [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
        logic [31:0] yo; logic [3:0] fo; int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ra[i], rb[i], rr[i], 1'b1, yo, fo, lat);
            total_cnt++; if ({fo, yo, lat} !== {rf[i], ry[i], LAT + 2})
                $display("FAIL range_%0d: %h/%h rm=%b got y=%h flags=%b lat=%0d expected y=%h flags=%b lat=%0d",
                         i, ra[i], rb[i], rr[i], yo, fo, lat, ry[i], rf[i], LAT + 2);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] yo; logic [3:0] fo; int lat; bit stable;
        do_op(32'h40C00000, 32'h40000000, 1'b0, 1'b0, yo, fo, lat);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || y !== 32'h40400000 || flags !== 4'b0000 || in_ready !== 1'b0) stable = 1'b0;
        end
        total_cnt++; if (stable !== 1'b1)
            $display("FAIL hold_stable: got out_valid=%b y=%h in_ready=%b expected 1/40400000/0", out_valid, y, in_ready); else pass_cnt++;
        drain();
        total_cnt++; if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL hold_drain: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] yo; logic [3:0] fo; int lat; bit quiet;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; round_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++; if ({out_valid, y, in_ready, md_reset} !== {1'b0, 32'h0, 1'b0, 1'b1})
            $display("FAIL abort_outputs: got out_valid=%b y=%h in_ready=%b md_reset=%b expected 0/00000000/0/1",
                     out_valid, y, in_ready, md_reset);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        quiet = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin @(negedge clk); if (out_valid !== 1'b0) quiet = 1'b0; end
        total_cnt++; if (quiet !== 1'b1) $display("FAIL abort_discard: got out_valid=1 expected 0"); else pass_cnt++;
        do_op(32'h40C00000, 32'h40000000, 1'b0, 1'b1, yo, fo, lat);
        total_cnt++; if ({fo, yo, lat} !== {4'b0000, 32'h40400000, LAT + 2})
            $display("FAIL abort_recover: got y=%h flags=%b lat=%0d expected y=40400000 flags=0000 lat=%0d", yo, fo, lat, LAT + 2);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, yo; logic [3:0] fo; logic rm; logic [35:0] exp_r; int lat, exp_lat;
        for (int n = 0; n < 150; n++) begin
            ra = rand_fp(); rb = rand_fp(); rm = 1'($urandom);
            exp_r = ref_div(ra, rb, rm);
            do_op(ra, rb, rm, 1'b0, yo, fo, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            total_cnt++; if ({y, flags} !== {yo, fo})
                $display("FAIL rand_hold_%0d: got y=%h flags=%b expected y=%h flags=%b", n, y, flags, yo, fo); else pass_cnt++;
            drain();
            total_cnt++; if ({fo, yo} !== exp_r)
                $display("FAIL rand_%0d: %h/%h rm=%b got y=%h flags=%b expected y=%h flags=%b",
                         n, ra, rb, rm, yo, fo, exp_r[31:0], exp_r[35:32]);
            else pass_cnt++;
            exp_lat = (ref_div(ra, rb, 1'b0) == ref_div(ra, rb, 1'b1) &&
                       (exp_r[35:34] != 2'b00 || (&ra[30:23]) || (&rb[30:23]) || ra[30:23] == 0 || rb[30:23] == 0)) ? 1 : LAT + 2;
            total_cnt++; if (lat !== exp_lat)
                $display("FAIL rand_latency_%0d: %h/%h got %0d expected %0d", n, ra, rb, lat, exp_lat); else pass_cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_range();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
